// File: rtl/ula_contention_pkg.sv
// Shared constants, state encoding and slot helper for the ULA contention block.
// Optional 128K geometry is enabled with ULA_CONTENTION_128K_EN.
package ula_contention_pkg;

    localparam logic [8:0] LINE_48K     = 9'd448;
    localparam logic [8:0] FRAME_48K    = 9'd312;
    localparam logic [8:0] LINE_128K    = 9'd456;
    localparam logic [8:0] FRAME_128K   = 9'd311;
    localparam logic [8:0] INT_LEN_48K  = 9'd64;
    localparam logic [8:0] INT_LEN_128K = 9'd72;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        GRANT = 2'd2
    } cont_state_e;

    // T-states 0..5 of each 8-T group (pixel phase 0..11) belong to the video fetch.
    function automatic logic slot_busy(input logic [3:0] phase, input logic in_display);
        return in_display && (phase < 4'd12);
    endfunction

endpackage

// File: rtl/ula_timing_counters.sv
// ULA pixel/line counters, frame-geometry latch and registered frame interrupt.
// Geometry select honoured only when ULA_CONTENTION_128K_EN is defined.
module ula_timing_counters
    import ula_contention_pkg::*;
#(
    parameter int INT_LINE = 248
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clk7en_i,
    input  logic       timing_128k_i,
    output logic [8:0] hc_o,
    output logic [8:0] vc_o,
    output logic       int_n_o
);

    localparam logic [8:0] INT_LINE_C = 9'(INT_LINE);

    logic [8:0] hc_q, hc_d;
    logic [8:0] vc_q, vc_d;
    logic       int_n_q, int_n_d;
    logic       geom_128k_q, geom_128k_d;
    logic [8:0] line_last_s, frame_last_s, int_len_s;
    logic       hc_wrap_s, vc_wrap_s;

`ifndef ULA_CONTENTION_128K_EN
    logic unused_timing_128k_s;
    assign unused_timing_128k_s = timing_128k_i;
`endif

    // Next-state for counters, geometry latch and interrupt
    always_comb begin
        line_last_s  = geom_128k_q ? (LINE_128K - 9'd1) : (LINE_48K - 9'd1);
        frame_last_s = geom_128k_q ? (FRAME_128K - 9'd1) : (FRAME_48K - 9'd1);
        int_len_s    = geom_128k_q ? INT_LEN_128K : INT_LEN_48K;
        hc_wrap_s    = clk7en_i && (hc_q == line_last_s);
        vc_wrap_s    = hc_wrap_s && (vc_q == frame_last_s);

        if (!clk7en_i) begin
            hc_d = hc_q;
        end else if (hc_wrap_s) begin
            hc_d = 9'd0;
        end else begin
            hc_d = hc_q + 9'd1;
        end

        if (!hc_wrap_s) begin
            vc_d = vc_q;
        end else if (vc_wrap_s) begin
            vc_d = 9'd0;
        end else begin
            vc_d = vc_q + 9'd1;
        end

        // Geometry only changes on the frame wrap so a frame is never mixed.
`ifdef ULA_CONTENTION_128K_EN
        if (vc_wrap_s) begin
            geom_128k_d = timing_128k_i;
        end else begin
            geom_128k_d = geom_128k_q;
        end
`else
        geom_128k_d = 1'b0;
`endif

        int_n_d = !((vc_q == INT_LINE_C) && (hc_q < int_len_s));
    end

    // Counter, geometry and interrupt registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hc_q        <= 9'd0;
            vc_q        <= 9'd0;
            int_n_q     <= 1'b1;
            geom_128k_q <= 1'b0;
        end else begin
            hc_q        <= hc_d;
            vc_q        <= vc_d;
            int_n_q     <= int_n_d;
            geom_128k_q <= geom_128k_d;
        end
    end

    assign hc_o    = hc_q;
    assign vc_o    = vc_q;
    assign int_n_o = int_n_q;

endmodule

// File: rtl/ula_contention.sv
// ULA memory/port contention: decides when the Z80 clock is held for a video slot.
// 128K frame geometry available with ULA_CONTENTION_128K_EN.
module ula_contention
    import ula_contention_pkg::*;
#(
    parameter int HC_PHASE  = 0,
    parameter int DISPLAY_W = 256,
    parameter int DISPLAY_H = 192,
    parameter int INT_LINE  = 248
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk7en,
    input  logic       clk35en_n,
    input  logic       mreq_n,
    input  logic       iorq_n,
    input  logic       addr_contended,
    input  logic       ula_port,
    input  logic       timing_128k,
    output logic [8:0] hc,
    output logic [8:0] vc,
    output logic       int_n,
    output logic       CPUContention
);

    localparam logic [3:0] HC_PHASE_C  = 4'(HC_PHASE);
    localparam logic [8:0] DISPLAY_W_C = 9'(DISPLAY_W);
    localparam logic [8:0] DISPLAY_H_C = 9'(DISPLAY_H);

    logic [8:0]  hc_s, vc_s;
    logic [3:0]  phase_s;
    logic        in_display_s, busy_slot_s, access_s;
    cont_state_e state_q;
    logic        contention_q;

    ula_timing_counters #(
        .INT_LINE (INT_LINE)
    ) u_counters (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .clk7en_i      (clk7en),
        .timing_128k_i (timing_128k),
        .hc_o          (hc_s),
        .vc_o          (vc_s),
        .int_n_o       (int_n)
    );

    // Slot classification and access decode
    always_comb begin
        phase_s      = hc_s[3:0] + HC_PHASE_C;
        in_display_s = (hc_s < DISPLAY_W_C) && (vc_s < DISPLAY_H_C);
        busy_slot_s  = slot_busy(phase_s, in_display_s);
        access_s     = (!mreq_n && addr_contended) || (!iorq_n && ula_port);
    end

    // Contention FSM, evaluated only on the CPU-phase sample enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            contention_q <= 1'b0;
        end else if (clk35en_n) begin
            case (state_q)
                IDLE: begin
                    if (access_s && busy_slot_s) begin
                        state_q      <= HOLD;
                        contention_q <= 1'b1;
                    end else if (access_s) begin
                        state_q      <= GRANT;
                        contention_q <= 1'b0;
                    end else begin
                        state_q      <= IDLE;
                        contention_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!access_s) begin
                        state_q      <= IDLE;
                        contention_q <= 1'b0;
                    end else if (busy_slot_s) begin
                        state_q      <= HOLD;
                        contention_q <= 1'b1;
                    end else begin
                        state_q      <= GRANT;
                        contention_q <= 1'b0;
                    end
                end
                // One contention per access: wait for the bus cycle to end.
                GRANT: begin
                    contention_q <= 1'b0;
                    if (mreq_n && iorq_n) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= GRANT;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    contention_q <= 1'b0;
                end
            endcase
        end else begin
            state_q      <= state_q;
            contention_q <= contention_q;
        end
    end

    assign hc            = hc_s;
    assign vc            = vc_s;
    assign CPUContention = contention_q;

endmodule

// File: tb/tb_ula_contention.sv
// Directed, table-driven bench for ula_contention (HC_PHASE=0 and HC_PHASE=4 instances).
module tb_ula_contention;
    import ula_contention_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, clk7en, clk35en_n, mreq_n, iorq_n, addr_contended, ula_port, timing_128k;
    logic [8:0] hc0, vc0, hc4, vc4;
    logic       int_n0, int_n4, cont0, cont4;

    int n_total = 0;
    int n_pass  = 0;

    logic       mon_en = 1'b0;
    int         int_low = 0;
    int         int_bad = 0;
    logic [8:0] max_hc = 9'd0;
    logic [8:0] max_vc = 9'd0;

    always #5 clk = ~clk;

    ula_contention #(.HC_PHASE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clk7en(clk7en), .clk35en_n(clk35en_n),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .addr_contended(addr_contended),
        .ula_port(ula_port), .timing_128k(timing_128k),
        .hc(hc0), .vc(vc0), .int_n(int_n0), .CPUContention(cont0)
    );

    ula_contention #(.HC_PHASE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clk7en(clk7en), .clk35en_n(clk35en_n),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .addr_contended(addr_contended),
        .ula_port(ula_port), .timing_128k(timing_128k),
        .hc(hc4), .vc(vc4), .int_n(int_n4), .CPUContention(cont4)
    );

    // Frame monitor: interrupt width/position and counter maxima
    always @(negedge clk) begin
        if (mon_en) begin
            if (hc0 > max_hc) max_hc <= hc0;
            if (vc0 > max_vc) max_vc <= vc0;
            if (!int_n0) begin
                int_low <= int_low + 1;
                if (vc0 != 9'd248) int_bad <= int_bad + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic advance_to(input logic [8:0] v, input logic [8:0] h);
        int n = 0;
        clk7en = 1'b1;
        while (!(hc0 == h && vc0 == v) && n < 200000) begin
            @(posedge clk); #1;
            n++;
        end
        clk7en = 1'b0;
        check($sformatf("reach_v%0d_h%0d", v, h), (n < 200000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic sample(input logic m, input logic i, input logic a, input logic p);
        mreq_n = m; iorq_n = i; addr_contended = a; ula_port = p;
        clk35en_n = 1'b1;
        @(posedge clk); #1;
        clk35en_n = 1'b0;
    endtask

    task automatic step7();
        clk7en = 1'b1;
        @(posedge clk); #1;
        clk7en = 1'b0;
    endtask

    typedef struct {
        logic [8:0] hc;
        logic       m, i, a, p;
        logic       exp_cont;
        logic [1:0] exp_st;
    } vec_t;

    vec_t vecs[19];

    initial begin
        // All vectors at vc=10, HC_PHASE=0: busy while (hc mod 16) < 12.
        vecs[0]  = '{9'd0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, HOLD};
        vecs[1]  = '{9'd5,   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, HOLD};
        vecs[2]  = '{9'd11,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, HOLD};
        vecs[3]  = '{9'd12,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, GRANT};
        vecs[4]  = '{9'd16,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, GRANT};
        vecs[5]  = '{9'd17,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, IDLE};
        vecs[6]  = '{9'd20,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE};
        vecs[7]  = '{9'd21,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, HOLD};
        vecs[8]  = '{9'd28,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, GRANT};
        vecs[9]  = '{9'd29,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, IDLE};
        vecs[10] = '{9'd32,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, HOLD};
        vecs[11] = '{9'd33,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, IDLE};
        vecs[12] = '{9'd40,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, HOLD};
        vecs[13] = '{9'd44,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, GRANT};
        vecs[14] = '{9'd45,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, GRANT};
        vecs[15] = '{9'd46,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, IDLE};
        vecs[16] = '{9'd48,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, IDLE};
        vecs[17] = '{9'd300, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, GRANT};
        vecs[18] = '{9'd301, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, IDLE};

        rst_n = 1'b0; clk7en = 1'b0; clk35en_n = 1'b0; timing_128k = 1'b0;
        mreq_n = 1'b1; iorq_n = 1'b1; addr_contended = 1'b0; ula_port = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hc", hc0, 9'd0);
        check("rst_vc", vc0, 9'd0);
        check("rst_int_n", int_n0, 1'b1);
        check("rst_cont", cont0, 1'b0);
        check("rst_state", dut0.state_q, IDLE);
        check("rst_hc4", hc4, 9'd0);
        check("rst_int_n4", int_n4, 1'b1);
        rst_n = 1'b1;
        timing_128k = 1'b1;

        for (int k = 0; k < 19; k++) begin
            advance_to(9'd10, vecs[k].hc);
            sample(vecs[k].m, vecs[k].i, vecs[k].a, vecs[k].p);
            check($sformatf("vec%0d_hc%0d_cont", k, vecs[k].hc), cont0, vecs[k].exp_cont);
            check($sformatf("vec%0d_hc%0d_state", k, vecs[k].hc), dut0.state_q, vecs[k].exp_st);
        end

        // Line-end boundary: with HC_PHASE=4 an access at hc=254 holds until hc=256.
        advance_to(9'd11, 9'd254);
        sample(1'b0, 1'b1, 1'b1, 1'b0);
        check("bnd254_cont4", cont4, 1'b1);
        check("bnd254_state4", dut4.state_q, HOLD);
        check("bnd254_cont0", cont0, 1'b0);
        check("bnd254_state0", dut0.state_q, GRANT);
        step7();
        sample(1'b0, 1'b1, 1'b1, 1'b0);
        check("bnd255_cont4", cont4, 1'b1);
        step7();
        sample(1'b0, 1'b1, 1'b1, 1'b0);
        check("bnd256_cont4", cont4, 1'b0);
        check("bnd256_state4", dut4.state_q, GRANT);
        sample(1'b1, 1'b1, 1'b1, 1'b0);
        check("bnd_rel_state4", dut4.state_q, IDLE);

        // Vertical border: no contention, straight to GRANT.
        advance_to(9'd200, 9'd0);
        sample(1'b0, 1'b1, 1'b1, 1'b0);
        check("border_cont", cont0, 1'b0);
        check("border_state", dut0.state_q, GRANT);
        sample(1'b1, 1'b1, 1'b1, 1'b0);
        check("border_rel_state", dut0.state_q, IDLE);

        // Rest of the 48K frame up to the wrap.
        mon_en = 1'b1;
        advance_to(9'd0, 9'd0);
        mon_en = 1'b0;
        @(negedge clk); #1;
        check("frame_max_hc", max_hc, 9'd447);
        check("frame_max_vc", max_vc, 9'd311);
        check("int_low_len", int_low, 64);
        check("int_off_line", int_bad, 0);

        // First line after the wrap: 128K geometry only if the feature is built in.
        max_hc = 9'd0;
        mon_en = 1'b1;
        advance_to(9'd1, 9'd0);
        mon_en = 1'b0;
        @(negedge clk); #1;
`ifdef ULA_CONTENTION_128K_EN
        check("line_after_wrap_max_hc", max_hc, 9'd455);
`else
        check("line_after_wrap_max_hc", max_hc, 9'd447);
`endif

        // Reset while holding drops CPUContention without waiting for a clock.
        sample(1'b0, 1'b1, 1'b1, 1'b0);
        check("prereset_cont", cont0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cont", cont0, 1'b0);
        check("async_rst_state", dut0.state_q, IDLE);
        check("async_rst_vc", vc0, 9'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mreq_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
